regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_sb_pending_table.sv | 45 ++++
 rtl/regfile_sb.sv | 73 +++++++
 tb/tb_regfile_sb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Widths here are the defaults; regfile_sb may be built with other widths.
package regfile_pkg;

    localparam int RF_ADDRESS_WIDTH = 5;
    localparam int RF_DATA_WIDTH    = 32;
    localparam int RF_A0_INDEX      = 'h10;

    typedef logic [RF_ADDRESS_WIDTH-1:0] reg_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0]    reg_data_t;

endpackage

// File: rtl/regfile_sb_pending_table.sv
// One pending bit per register, marking an issued long-latency producer whose
// result has not yet been written back. Register 0 is never pending.
module pending_table #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_RD        = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            set_en,
    input  logic [ADDRESS_WIDTH-1:0]        set_addr,
    input  logic                            clr_en,
    input  logic [ADDRESS_WIDTH-1:0]        clr_addr,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] lookup_addr,
    output logic [NUM_RD-1:0]               lookup_pending,
    output logic                            any_pending
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DEPTH-1:1] pending;
    logic [DEPTH-1:0] pending_full;

    // A set on the same edge as a clear wins: the newer producer is still outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            for (int n = 1; n < DEPTH; n++) begin
                if (set_en && set_addr == ADDRESS_WIDTH'(n)) begin
                    pending[n] <= 1'b1;
                end else if (clr_en && clr_addr == ADDRESS_WIDTH'(n)) begin
                    pending[n] <= 1'b0;
                end
            end
        end
    end

    assign pending_full = {pending, 1'b0};
    assign any_pending  = |pending;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
        assign lookup_pending[i] = pending_full[lookup_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through reads and a pending-producer scoreboard.
// Register 0 is hardwired to zero and can never be marked pending.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int NUM_RD        = 2,
    parameter int A0_INDEX      = RF_A0_INDEX
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]               rd_busy,
    input  logic                            we,
    input  logic [ADDRESS_WIDTH-1:0]        wa,
    input  logic [DATA_WIDTH-1:0]           wd,
    input  logic                            iss,
    input  logic [ADDRESS_WIDTH-1:0]        iss_addr,
    output logic [DATA_WIDTH-1:0]           a0,
    output logic                            any_busy
);

    localparam int                 DEPTH   = 2 ** ADDRESS_WIDTH;
    localparam [ADDRESS_WIDTH-1:0] A0_ADDR = ADDRESS_WIDTH'(A0_INDEX);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [NUM_RD-1:0]     lookup_pending;
    logic                  wb_live;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                mem[n] <= '0;
            end
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    pending_table #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .NUM_RD       (NUM_RD)
    ) u_pending (
        .clk           (clk),
        .rst           (rst),
        .set_en        (iss && iss_addr != '0),
        .set_addr      (iss_addr),
        .clr_en        (we),
        .clr_addr      (wa),
        .lookup_addr   (rd_addr),
        .lookup_pending(lookup_pending),
        .any_pending   (any_busy)
    );

    // Forwarding is suppressed under reset so every output reads zero while rst is high.
    assign wb_live = we && wa != '0 && !rst;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr;
        assign addr = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
            (rst || addr == '0)       ? '0 :
            (wb_live && wa == addr)   ? wd : mem[addr];
        // A writeback landing this cycle already satisfies the reader.
        assign rd_busy[i] = lookup_pending[i] && !(we && wa == addr);
    end

    assign a0 = (rst || A0_ADDR == '0)    ? '0 :
                (wb_live && wa == A0_ADDR) ? wd : mem[A0_ADDR];

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb (three read ports) with a
// queue-based scoreboard fed by the driver and drained by a negedge monitor.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NRD = 3;
    localparam int A0I = 'h10;

    typedef struct packed {
        logic [NRD*DW-1:0] data;
        logic [NRD-1:0]    busy;
        logic [DW-1:0]     a0;
        logic              any;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [DW-1:0]       wd;
    logic                iss;
    logic [AW-1:0]       iss_addr;
    logic [DW-1:0]       a0;
    logic                any_busy;

    regfile_sb #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .NUM_RD       (NRD),
        .A0_INDEX     (A0I)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .iss     (iss),
        .iss_addr(iss_addr),
        .a0      (a0),
        .any_busy(any_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    reg_data_t   model_regs [32];
    bit          model_pend [32];
    logic [EW-1:0] exp_q [$];

    int n_total = 0;
    int n_pass  = 0;
    int n_pushed = 0;
    int n_popped = 0;

    task automatic model_clear();
        for (int n = 0; n < 32; n++) begin
            model_regs[n] = '0;
            model_pend[n] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (rst || a == 0) return '0;
        if (we && wa != 0 && wa == a) return wd;
        return model_regs[a];
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] a);
        if (rst) return 1'b0;
        return model_pend[a] && !(we && wa == a);
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic i, input logic [AW-1:0] ia,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2);
        exp_t e;
        bit   any;
        rst = r; we = w; wa = a; wd = d; iss = i; iss_addr = ia;
        rd_addr = {r2, r1, r0};
        if (r) model_clear();
        e.data = {model_read(r2), model_read(r1), model_read(r0)};
        e.busy = {model_busy(r2), model_busy(r1), model_busy(r0)};
        e.a0   = model_read(AW'(A0I));
        any = 1'b0;
        for (int n = 0; n < 32; n++) any |= model_pend[n];
        e.any = any;
        exp_q.push_back(e);
        n_pushed++;
        @(posedge clk);
        if (!r) begin
            if (w && a != 0) model_regs[a] = d;
            for (int n = 1; n < 32; n++) begin
                if (i && ia == AW'(n)) model_pend[n] = 1'b1;
                else if (w && a == AW'(n)) model_pend[n] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic read3(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, r0, r1, r2);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, 31));
    endfunction

    // ---------------- scoreboard monitor ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s entry=%0d act=%h exp=%h", name, n_popped, act, exp);
        else n_pass++;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_t'(exp_q.pop_front());
                n_popped++;
                check("rd_data", 128'(rd_data), 128'(e.data));
                check("rd_busy", 128'(rd_busy), 128'(e.busy));
                check("a0", 128'(a0), 128'(e.a0));
                check("any_busy", 128'(any_busy), 128'(e.any));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        model_clear();
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; iss = 1'b0; iss_addr = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;

        // Writes and issues while in reset are ignored
        drive(1'b1, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd3, 5'd5, 5'd3, 5'd16);
        // First edge after deassert performs its write
        drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd4, 5'd5, 5'd4, 5'd0);
        drive(1'b0, 1'b1, 5'd16, 32'h1616_1616, 1'b0, 5'd0, 5'd5, 5'd16, 5'd4);
        read3(5'd5, 5'd16, 5'd4);
        // Mid-cycle async reset: everything reads zero before the next edge
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd16, 5'd4);
        read3(5'd5, 5'd16, 5'd4);

        // Write-through then stored value
        drive(1'b0, 1'b1, 5'd7, 32'h0000_1234, 1'b0, '0, 5'd7, 5'd1, 5'd2);
        read3(5'd7, 5'd7, 5'd0);

        // x0 writes and issues have no effect
        drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
        read3(5'd0, 5'd0, 5'd0);

        // Issue x3, busy for k cycles, writeback clears
        k = 3;
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd3, 5'd1);
        for (int c = 0; c < k; c++) read3(5'd3, 5'd2, 5'd3);
        drive(1'b0, 1'b1, 5'd3, 32'h0000_0055, 1'b0, '0, 5'd3, 5'd3, 5'd3);
        read3(5'd3, 5'd3, 5'd3);

        // Collision: new producer wins the pending bit, data is still stored
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd9, 32'h0000_00AA, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9);
        read3(5'd9, 5'd9, 5'd9);
        read3(5'd9, 5'd1, 5'd9);
        drive(1'b0, 1'b1, 5'd9, 32'h0000_00BB, 1'b0, '0, 5'd9, 5'd9, 5'd9);
        read3(5'd9, 5'd9, 5'd9);

        // All ports and a0 on x16 during its writeback
        drive(1'b0, 1'b1, 5'd16, 32'h0000_0010, 1'b0, '0, 5'd16, 5'd16, 5'd16);
        read3(5'd16, 5'd16, 5'd16);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 1) == 1), rand_addr(), $urandom(),
                  ($urandom_range(0, 3) == 0), rand_addr(),
                  rand_addr(), rand_addr(), rand_addr());
        end
        read3(5'd16, 5'd1, 5'd2);

        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clk);
        @(negedge clk);
        n_total++;
        if (exp_q.size() != 0 || n_popped != n_pushed)
            $display("FAIL drain pending=%0d popped=%0d pushed=%0d", exp_q.size(), n_popped, n_pushed);
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
